frame_bank_scheduler: RTL

//  Sequences the SPI data FSM against display timing using ping-pong video/audio memory banks.

---
 rtl/frame_bank_scheduler_pkg.sv | 20 ++
 rtl/frame_bank_scheduler_bank_addr_gen.sv | 29 ++
 rtl/frame_bank_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/frame_bank_scheduler_pkg.sv
// Shared parameters and types for the frame bank scheduler.
//   VIDEO_MEM_CELL_COUNT / AUDIO_MEM_CELL_COUNT : cells per bank (one bit each)
//   DEFAULT_TIMEOUT_CYCLES                      : CLK_40 cycles allowed per fill state (1 s)
//   fbs_state_t                                 : scheduler FSM state encoding
package frame_bank_scheduler_pkg;

    localparam int VIDEO_MEM_CELL_COUNT   = 4800;
    localparam int AUDIO_MEM_CELL_COUNT   = 1024;
    localparam int DEFAULT_TIMEOUT_CYCLES = 40_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQUEST   = 3'd1,
        ST_FILL_V    = 3'd2,
        ST_FILL_A    = 3'd3,
        ST_WAIT_SWAP = 3'd4,
        ST_ABORT     = 3'd5
    } fbs_state_t;

endpackage

// File: rtl/frame_bank_scheduler_bank_addr_gen.sv
// Write-address counter for one memory bank.
//   CLK_40 : clock            reset : synchronous, active-high
//   clear  : force address 0 (wins over inc)
//   inc    : advance after the current cell is written; wraps to 0 after DEPTH-1
//   addr   : current write address
//   last   : addr is the final cell (DEPTH-1)
module bank_addr_gen #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK_40,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          last
);

    assign last = (addr == AW'(DEPTH - 1));

    always_ff @(posedge CLK_40) begin
        if (reset || clear) begin
            addr <= '0;
        end else if (inc) begin
            addr <= last ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Frame bank scheduler: requests transfers from the SPI data FSM, steers the
// received video/audio bits into the write bank of a ping-pong pair and hands
// the freshly filled bank to the display at its frame boundary.
//   CLK_40, reset                  : clock, synchronous active-high reset
//   run                            : level, allows a new request (sampled in IDLE)
//   frame_done                     : display end-of-frame pulse
//   data_clk_rising_edge           : qualifies the data-FSM outputs below
//   video_data_ready / audio_data_ready / received_bit : data-FSM bit stream
//   start_req                      : one-cycle transfer request to the data FSM
//   rd_bank                        : bank read by the display (write bank = ~rd_bank)
//   vid_we/vid_waddr, aud_we/aud_waddr, wdata : write port into the write bank
//   bank_valid                     : sticky, a full frame has been swapped in
//   underrun                       : pulse, frame ended without a fresh bank
//   timeout_err                    : sticky, a fill was abandoned on timeout
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for run
// ST_REQUEST   | start_req asserted for this single cycle
// ST_FILL_V    | accepting video bits into the write bank
// ST_FILL_A    | accepting audio bits into the write bank
// ST_WAIT_SWAP | write bank complete, waiting for frame_done to swap
// ST_ABORT     | fill timed out; partial bank discarded, addresses cleared
module frame_bank_scheduler
    import frame_bank_scheduler_pkg::*;
#(
    parameter  int VIDEO_CELLS    = VIDEO_MEM_CELL_COUNT,
    parameter  int AUDIO_CELLS    = AUDIO_MEM_CELL_COUNT,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int VAW            = $clog2(VIDEO_CELLS),
    localparam int AAW            = $clog2(AUDIO_CELLS),
    localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic           CLK_40,
    input  logic           reset,
    input  logic           run,
    input  logic           frame_done,
    input  logic           data_clk_rising_edge,
    input  logic           video_data_ready,
    input  logic           audio_data_ready,
    input  logic           received_bit,
    output logic           start_req,
    output logic           rd_bank,
    output logic           vid_we,
    output logic           aud_we,
    output logic [VAW-1:0] vid_waddr,
    output logic [AAW-1:0] aud_waddr,
    output logic           wdata,
    output logic           bank_valid,
    output logic           underrun,
    output logic           timeout_err
);

    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    fbs_state_t    state_q, state_d;
    logic [TW-1:0] tmr_q;
    logic          in_fill, tmr_expired, tmr_load;
    logic          vid_last, aud_last, vid_accept, aud_accept, addr_clear;

    // Down-counter loaded on fill-state entry; reaching zero marks the
    // TIMEOUT_CYCLES-th cycle spent in that state.
    assign in_fill     = (state_q == ST_FILL_V) || (state_q == ST_FILL_A);
    assign tmr_expired = in_fill && (tmr_q == '0);
    assign tmr_load    = ((state_d == ST_FILL_V) && (state_q != ST_FILL_V)) ||
                         ((state_d == ST_FILL_A) && (state_q != ST_FILL_A));

    // The write of the final cell is in flight while the state is still the
    // fill state; a strobe arriving in that cycle would overflow the bank.
    assign vid_accept = (state_q == ST_FILL_V) && data_clk_rising_edge &&
                        video_data_ready && !(vid_we && vid_last);
    assign aud_accept = (state_q == ST_FILL_A) && data_clk_rising_edge &&
                        audio_data_ready && !(aud_we && aud_last);

    assign addr_clear = (state_q == ST_ABORT) || (state_q == ST_REQUEST);

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                start_req = !reset;
                state_d   = ST_FILL_V;
            end
            ST_FILL_V: begin
                // A committed final write still loses to the timeout.
                if (tmr_expired)              state_d = ST_ABORT;
                else if (vid_we && vid_last)  state_d = ST_FILL_A;
            end
            ST_FILL_A: begin
                if (tmr_expired)              state_d = ST_ABORT;
                else if (aud_we && aud_last)  state_d = ST_WAIT_SWAP;
            end
            ST_WAIT_SWAP: begin
                if (frame_done) state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            tmr_q <= '0;
        end else if (tmr_load) begin
            tmr_q <= TMR_LOAD;
        end else if (in_fill && (tmr_q != '0)) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            vid_we      <= 1'b0;
            aud_we      <= 1'b0;
            wdata       <= 1'b0;
            rd_bank     <= 1'b0;
            bank_valid  <= 1'b0;
            underrun    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            vid_we   <= vid_accept;
            aud_we   <= aud_accept;
            wdata    <= received_bit;
            underrun <= frame_done && (state_q != ST_WAIT_SWAP);
            if ((state_q == ST_WAIT_SWAP) && frame_done) begin
                rd_bank    <= ~rd_bank;
                bank_valid <= 1'b1;
            end
            if (state_d == ST_ABORT) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Address advances after the write cycle, so the strobe and the address
    // it targets are presented together.
    bank_addr_gen #(.DEPTH(VIDEO_CELLS)) u_vid_addr (
        .CLK_40 (CLK_40),
        .reset  (reset),
        .clear  (addr_clear),
        .inc    (vid_we),
        .addr   (vid_waddr),
        .last   (vid_last)
    );

    bank_addr_gen #(.DEPTH(AUDIO_CELLS)) u_aud_addr (
        .CLK_40 (CLK_40),
        .reset  (reset),
        .clear  (addr_clear),
        .inc    (aud_we),
        .addr   (aud_waddr),
        .last   (aud_last)
    );

endmodule
